// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the weighted round-robin bus scheduler.
// Default sizes, FSM state encoding and the destination-field decode.
package bus_arb_pkg;

  localparam int DRVRS_DEF   = 4;
  localparam int PCKG_SZ_DEF = 16;
  localparam int WGT_W_DEF   = 4;
  localparam int PKT_MAX     = 64;
  localparam logic [7:0] BROADCAST_DEF = 8'hFF;

  typedef enum logic {IDLE, HOLD} state_t;

  typedef logic [$clog2(DRVRS_DEF)-1:0] idx_t;
  typedef logic [WGT_W_DEF-1:0]         wgt_t;

  // Destination id sits in the top byte of a packet of width sz.
  function automatic logic [7:0] dest_of(input logic [PKT_MAX-1:0] pkt, input int unsigned sz);
    return 8'(pkt >> (sz - 8));
  endfunction

endpackage

// File: rtl/bus_wrr_scheduler_rr_pick.sv
// Circular priority encoder: first set bit of i_eligible at or after i_ptr.
// o_winner is meaningless when o_any is low.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_eligible,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_winner,
  output logic          o_any
);

  logic [N-1:0]  w_rot;
  logic [IW-1:0] w_off;
  logic [IW:0]   w_sum;

  // Rotate so that bit 0 corresponds to the device at i_ptr.
  assign w_rot = N'({i_eligible, i_eligible} >> i_ptr);
  assign o_any = |i_eligible;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    w_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IW'(k);
    end
    w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    if (w_sum >= (IW+1)'(N)) w_sum = w_sum - (IW+1)'(N);
    o_winner = w_sum[IW-1:0];
  end

endmodule

// File: rtl/bus_wrr_scheduler.sv
// Weighted round-robin scheduler: pops one packet from the winning device FIFO
// and holds it on a valid/ready port; per-device weights set the bus share.
module bus_wrr_scheduler
  import bus_arb_pkg::*;
#(
  parameter int         DRVRS     = DRVRS_DEF,
  parameter int         PCKG_SZ   = PCKG_SZ_DEF,
  parameter int         WGT_W     = WGT_W_DEF,
  parameter logic [7:0] BROADCAST = BROADCAST_DEF,
  localparam int        IW        = $clog2(DRVRS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DRVRS-1:0]                pndng,
  input  logic [DRVRS-1:0][PCKG_SZ-1:0]   D_pop,
  output logic [DRVRS-1:0]                pop,
  input  logic                            cfg_we,
  input  logic [IW-1:0]                   cfg_idx,
  input  logic [WGT_W-1:0]                cfg_wgt,
  output logic                            gnt_vld,
  input  logic                            gnt_rdy,
  output logic [IW-1:0]                   gnt_id,
  output logic [PCKG_SZ-1:0]              gnt_data,
  output logic [7:0]                      gnt_dest,
  output logic                            gnt_bcast
);

  state_t               r_state, w_next;
  logic [WGT_W-1:0]     r_wgt [DRVRS];
  logic [WGT_W-1:0]     r_credit;
  logic [IW-1:0]        r_ptr;
  logic [IW-1:0]        r_id;
  logic [PCKG_SZ-1:0]   r_data;
  logic                 r_vld;
  logic [DRVRS-1:0]     r_pop;

  logic [DRVRS-1:0]     w_elig;
  logic [IW-1:0]        w_win;
  logic                 w_any;
  logic [WGT_W-1:0]     w_c;
  logic [IW-1:0]        w_ptr_inc;

  always_comb begin
    for (int i = 0; i < DRVRS; i++) w_elig[i] = pndng[i] & (r_wgt[i] != '0);
  end

  rr_pick #(.N(DRVRS), .IW(IW)) u_pick (
    .i_eligible (w_elig),
    .i_ptr      (r_ptr),
    .o_winner   (w_win),
    .o_any      (w_any)
  );

  // Remaining credit belongs to ptr only; any other winner starts from its full weight.
  assign w_c       = (r_id == r_ptr) ? r_credit : r_wgt[r_id];
  assign w_ptr_inc = (r_id == IW'(DRVRS - 1)) ? '0 : r_id + IW'(1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any)   w_next = HOLD;
      HOLD:    if (gnt_rdy) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: the weight table is a small flop array, not a RAM macro, so it is reset like any register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_pop    <= '0;
      r_vld    <= 1'b0;
      r_id     <= '0;
      r_data   <= '0;
      r_ptr    <= '0;
      r_credit <= WGT_W'(1);
      for (int i = 0; i < DRVRS; i++) r_wgt[i] <= WGT_W'(1);
    end else begin
      r_state <= w_next;
      r_pop   <= '0;
      if (cfg_we && ({1'b0, cfg_idx} < (IW+1)'(DRVRS))) r_wgt[cfg_idx] <= cfg_wgt;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_id   <= w_win;
            r_data <= D_pop[w_win];
            r_vld  <= 1'b1;
            r_pop  <= DRVRS'(1) << w_win;
          end
        end
        HOLD: begin
          if (gnt_rdy) begin
            r_vld <= 1'b0;
            if (w_c > WGT_W'(1)) begin
              r_ptr    <= r_id;
              r_credit <= w_c - WGT_W'(1);
            end else begin
              r_ptr    <= w_ptr_inc;
              r_credit <= r_wgt[w_ptr_inc];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign pop       = r_pop;
  assign gnt_vld   = r_vld;
  assign gnt_id    = r_id;
  assign gnt_data  = r_data;
  assign gnt_dest  = dest_of(PKT_MAX'(r_data), PCKG_SZ);
  assign gnt_bcast = (gnt_dest == BROADCAST);

endmodule

// File: tb/tb_bus_wrr_scheduler.sv
// Scoreboard bench for bus_wrr_scheduler: expected grants are queued with the
// stimulus and compared as the scheduler pops each packet.
module tb_bus_wrr_scheduler;

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        pndng;
  logic [3:0][15:0]  D_pop;
  logic [3:0]        pop;
  logic              cfg_we;
  logic [1:0]        cfg_idx;
  logic [3:0]        cfg_wgt;
  logic              gnt_vld;
  logic              gnt_rdy;
  logic [1:0]        gnt_id;
  logic [15:0]       gnt_data;
  logic [7:0]        gnt_dest;
  logic              gnt_bcast;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  bus_wrr_scheduler #(.DRVRS(4), .PCKG_SZ(16), .WGT_W(4), .BROADCAST(8'hFF)) dut (
    .clk       (clk),
    .reset     (reset),
    .pndng     (pndng),
    .D_pop     (D_pop),
    .pop       (pop),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_wgt   (cfg_wgt),
    .gnt_vld   (gnt_vld),
    .gnt_rdy   (gnt_rdy),
    .gnt_id    (gnt_id),
    .gnt_data  (gnt_data),
    .gnt_dest  (gnt_dest),
    .gnt_bcast (gnt_bcast)
  );

  function automatic logic [15:0] pattern(input int i);
    return 16'(32'h0100 * i + 32'h00A0 + i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_id(input int id);
    exp_t e;
    e.id   = 2'(id);
    e.data = pattern(id);
    exp_q.push_back(e);
  endtask

  task automatic write_wgt(input int idx, input int w);
    cfg_we  = 1'b1;
    cfg_idx = 2'(idx);
    cfg_wgt = 4'(w);
    tick();
    cfg_we  = 1'b0;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    pndng   = '0;
    gnt_rdy = 1'b0;
    cfg_we  = 1'b0;
    cfg_idx = '0;
    cfg_wgt = '0;
    for (int i = 0; i < 4; i++) D_pop[i] = pattern(i);
    tick();
    tick();
    reset = 1'b1;
    exp_q.delete();
  endtask

  // Monitor: every pop must be one-hot, single-cycle, match gnt_id and the queued grant.
  task automatic drain(input int n, input string tag);
    int         got = 0;
    int         cyc = 0;
    logic [3:0] prev_pop = '0;
    exp_t       e;
    while (got < n && cyc < 20 * n) begin
      tick();
      cyc++;
      if (pop !== 4'b0000) begin
        n_cmp++;
        if (pop !== (4'b0001 << gnt_id) || gnt_vld !== 1'b1) begin
          n_bad++;
          $display("FAIL %s_pop: pop=%b vld=%b id=%0d expected one-hot of id with vld=1", tag, pop, gnt_vld, gnt_id);
        end
        n_cmp++;
        if (prev_pop !== 4'b0000) begin
          n_bad++;
          $display("FAIL %s_pop_width: pop=%b held for more than one cycle", tag, pop);
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL %s_extra: unexpected grant id=%0d", tag, gnt_id);
        end else begin
          e = exp_q.pop_front();
          if (gnt_id !== e.id || gnt_data !== e.data) begin
            n_bad++;
            $display("FAIL %s_grant%0d: id=%0d data=%h expected id=%0d data=%h", tag, got, gnt_id, gnt_data, e.id, e.data);
          end
        end
        got++;
      end
      prev_pop = pop;
    end
    n_cmp++;
    if (got != n || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_count: got %0d grants expected %0d (%0d left in queue)", tag, got, n, exp_q.size());
    end
    pndng = '0;
    tick();
    tick();
  endtask

  task automatic wait_pop(input logic [3:0] want, input string tag);
    int k = 0;
    do begin
      tick();
      k++;
    end while (pop === 4'b0000 && k < 8);
    n_cmp++;
    if (pop !== want) begin
      n_bad++;
      $display("FAIL %s: pop=%b expected %b", tag, pop, want);
    end
  endtask

  task automatic test_reset();
    int seq [6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    write_wgt(0, 3);
    pndng   = 4'b0100;
    gnt_rdy = 1'b0;
    wait_pop(4'b0100, "reset_setup_pop");
    tick();
    tick();
    reset = 1'b0;
    tick();
    n_cmp++;
    if (pop !== 4'b0000) begin n_bad++; $display("FAIL reset_pop: pop=%b expected 0000", pop); end
    n_cmp++;
    if (gnt_vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld: gnt_vld=%b expected 0", gnt_vld); end
    n_cmp++;
    if (gnt_id !== 2'd0) begin n_bad++; $display("FAIL reset_id: gnt_id=%0d expected 0", gnt_id); end
    n_cmp++;
    if (gnt_data !== 16'h0000 || gnt_bcast !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_data: gnt_data=%h bcast=%b expected 0000/0", gnt_data, gnt_bcast);
    end
    tick();
    reset   = 1'b1;
    pndng   = 4'b1111;
    gnt_rdy = 1'b1;
    foreach (seq[i]) push_id(seq[i]);
    drain(6, "reset_wgt_seq");
  endtask

  task automatic test_round_robin();
    int seq [5] = '{0, 1, 2, 3, 0};
    do_reset();
    pndng   = 4'b1111;
    gnt_rdy = 1'b1;
    foreach (seq[i]) push_id(seq[i]);
    drain(5, "rr");
  endtask

  task automatic test_weighted();
    int seq [13] = '{0, 1, 2, 3, 0, 0, 0, 1, 2, 3, 0, 0, 0};
    do_reset();
    for (int i = 0; i < 4; i++) write_wgt(i, (i == 0) ? 3 : 1);
    pndng   = 4'b1111;
    gnt_rdy = 1'b1;
    foreach (seq[i]) push_id(seq[i]);
    drain(13, "wrr");
  endtask

  task automatic test_hold_stall();
    int pops = 1;
    int bad  = 0;
    do_reset();
    pndng   = 4'b0010;
    gnt_rdy = 1'b0;
    wait_pop(4'b0010, "stall_first_pop");
    for (int c = 0; c < 5; c++) begin
      tick();
      if (c == 1) pndng = 4'b0000;
      if (gnt_vld !== 1'b1 || gnt_id !== 2'd1 || gnt_data !== pattern(1)) bad++;
      if (pop !== 4'b0000) pops++;
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL stall_stable: %0d unstable cycles expected 0", bad); end
    n_cmp++;
    if (pops != 1) begin n_bad++; $display("FAIL stall_pops: %0d pops expected 1", pops); end
    gnt_rdy = 1'b1;
    tick();
    n_cmp++;
    if (gnt_vld !== 1'b0) begin n_bad++; $display("FAIL stall_accept: gnt_vld=%b expected 0", gnt_vld); end
    tick();
    n_cmp++;
    if (gnt_vld !== 1'b0 || pop !== 4'b0000) begin
      n_bad++;
      $display("FAIL stall_idle_rdy: vld=%b pop=%b expected 0/0000", gnt_vld, pop);
    end
  endtask

  task automatic test_bcast();
    do_reset();
    D_pop[2] = 16'hFF12;
    pndng    = 4'b0100;
    gnt_rdy  = 1'b0;
    wait_pop(4'b0100, "bcast_pop");
    n_cmp++;
    if (gnt_dest !== 8'hFF || gnt_bcast !== 1'b1 || gnt_data !== 16'hFF12) begin
      n_bad++;
      $display("FAIL bcast_set: data=%h dest=%h bcast=%b expected FF12/FF/1", gnt_data, gnt_dest, gnt_bcast);
    end
    D_pop[2] = 16'h0312;
    tick();
    n_cmp++;
    if (gnt_data !== 16'hFF12) begin n_bad++; $display("FAIL bcast_latched: data=%h expected FF12", gnt_data); end
    gnt_rdy = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (pop !== 4'b0100 || gnt_data !== 16'h0312 || gnt_dest !== 8'h03 || gnt_bcast !== 1'b0) begin
      n_bad++;
      $display("FAIL bcast_clear: pop=%b data=%h dest=%h bcast=%b expected 0100/0312/03/0", pop, gnt_data, gnt_dest, gnt_bcast);
    end
  endtask

  task automatic test_mask();
    int bad = 0;
    do_reset();
    write_wgt(1, 0);
    pndng   = 4'b0010;
    gnt_rdy = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (pop !== 4'b0000 || gnt_vld !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL mask_idle: %0d grant cycles expected 0", bad); end
    write_wgt(1, 2);
    n_cmp++;
    if (pop !== 4'b0000) begin n_bad++; $display("FAIL mask_write_edge: pop=%b expected 0000", pop); end
    tick();
    n_cmp++;
    if (pop !== 4'b0010 || gnt_id !== 2'd1) begin
      n_bad++;
      $display("FAIL mask_unmask: pop=%b id=%0d expected 0010/1", pop, gnt_id);
    end
    pndng = 4'b0000;
    for (int i = 0; i < 4; i++) write_wgt(i, 0);
    pndng = 4'b1111;
    bad   = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (pop !== 4'b0000) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL mask_all_zero: %0d pops expected 0", bad); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_weighted();
    test_hold_stall();
    test_bcast();
    test_mask();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
